uart_cmd_ctrl: RTL and testbench

- Command sequencer between the UART link block's buffers and an on-chip register bus.
- Pops 32-bit command words from the UART input buffer and decodes them.
- Performs register reads/writes over a simple req/ack bus.
- Pushes response words into the UART output buffer, making the UART a host-controlled register access port.

---
 rtl/uart_ctrl_pkg.sv | 45 ++++
 rtl/uart_cmd_ctrl_if.sv | 37 +++
 rtl/uart_bus_timer.sv | 40 ++++
 rtl/uart_cmd_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and constants for the UART command sequencer:
//   opcode_t  - command opcodes carried in cmd[31:24]
//   status_t  - status byte placed in every response header
//   state_t   - sequencer states
//   field positions of the command word and a header-builder helper
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

    typedef enum logic [7:0] {
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_PING  = 8'h03
    } opcode_t;

    typedef enum logic [7:0] {
        ST_OK      = 8'h00,
        ST_BAD_OP  = 8'h01,
        ST_TIMEOUT = 8'h02
    } status_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        GET_DATA  = 3'd2,
        BUS       = 3'd3,
        SEND_HDR  = 3'd4,
        SEND_DATA = 3'd5
    } state_t;

    // Command word layout: [31:24] opcode, [23:16] ignored, [15:0] address
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 0;

    // Response header layout mirrors the command: {opcode, status, addr}
    function automatic logic [31:0] make_hdr(input logic [7:0]  opc,
                                             input status_t     st,
                                             input logic [15:0] addr);
        return {opc, st, addr};
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Bundles the UART buffer handshakes and the register bus.
//   UART input buffer : empty_in, data_from_uart (show-ahead), r_buff_in (pop)
//   UART output buffer: full_out, data_from_system, w_buff_out (push)
//   Register bus      : bus_req, bus_we, bus_addr, bus_wdata, bus_rdata, bus_ack
// modport master: the command sequencer; modport slave: buffers + bus fabric.
// -----------------------------------------------------------------------------
interface uart_cmd_ctrl_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 16
);
    logic                 empty_in;
    logic [WORD_SIZE-1:0] data_from_uart;
    logic                 r_buff_in;
    logic                 full_out;
    logic [WORD_SIZE-1:0] data_from_system;
    logic                 w_buff_out;
    logic                 bus_req;
    logic                 bus_we;
    logic [ADDR_W-1:0]    bus_addr;
    logic [WORD_SIZE-1:0] bus_wdata;
    logic [WORD_SIZE-1:0] bus_rdata;
    logic                 bus_ack;

    modport master (
        input  empty_in, data_from_uart, full_out, bus_rdata, bus_ack,
        output r_buff_in, data_from_system, w_buff_out,
               bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output empty_in, data_from_uart, full_out, bus_rdata, bus_ack,
        input  r_buff_in, data_from_system, w_buff_out,
               bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/uart_bus_timer.sv
// -----------------------------------------------------------------------------
// uart_bus_timer
// Loadable down-counter bounding a register bus transaction.
//   clock, reset (async, active-low)
//   clr     : force count to zero
//   load    : load BUS_TIMEOUT-1 (asserted on the cycle before the first BUS cycle)
//   en      : count down while the bus transaction is outstanding
//   expired : high during the BUS_TIMEOUT-th enabled cycle
// -----------------------------------------------------------------------------
module uart_bus_timer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int                CNT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BUS_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // Loading N-1 makes the Nth enabled cycle the one that sees zero.
    assign expired = en && (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Command sequencer turning the UART link into a host-controlled register
// access port. Pops command words, performs register bus reads/writes and
// pushes response headers (plus read data) back to the UART.
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-low reset
//   io         : uart_cmd_ctrl_if.master (UART buffers + register bus)
//   busy       : high whenever the sequencer is not IDLE
//   err_count  : saturating count of BAD_OPCODE / TIMEOUT headers pushed
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_W      = 16,
    parameter int BUS_TIMEOUT = 255,
    parameter int ERR_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    uart_cmd_ctrl_if.master    io,
    output logic               busy,
    output logic [ERR_W-1:0]   err_count
);

    state_t               state;
    logic [7:0]           cmd_op;
    logic [15:0]          cmd_addr;
    logic [WORD_SIZE-1:0] rdata;
    status_t              status;
    logic                 bus_req_r;
    logic                 bus_we_r;
    logic [ADDR_W-1:0]    bus_addr_r;
    logic [WORD_SIZE-1:0] bus_wdata_r;
    logic [WORD_SIZE-1:0] dout;
    logic                 busy_r;
    logic [ERR_W-1:0]     err_r;

    logic tmr_load;
    logic tmr_expired;

    function automatic logic [WORD_SIZE-1:0] hdr_word(input status_t st);
        return WORD_SIZE'(make_hdr(cmd_op, st, cmd_addr));
    endfunction

    // The timer is armed on whichever transition enters BUS.
    assign tmr_load = ((state == DECODE) && (cmd_op == OP_READ)) ||
                      ((state == GET_DATA) && !io.empty_in);

    uart_bus_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (state == IDLE),
        .load    (tmr_load),
        .en      (state == BUS),
        .expired (tmr_expired)
    );

    // Pop/push strobes are combinational so a word moves in the same cycle the
    // buffer allows it; gated by reset so nothing is consumed while held.
    assign io.r_buff_in  = reset && !io.empty_in &&
                           ((state == IDLE) || (state == GET_DATA));
    assign io.w_buff_out = reset && !io.full_out &&
                           ((state == SEND_HDR) || (state == SEND_DATA));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_op      <= '0;
            cmd_addr    <= '0;
            rdata       <= '0;
            status      <= ST_OK;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            dout        <= '0;
            busy_r      <= 1'b0;
            err_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!io.empty_in) begin
                        cmd_op   <= io.data_from_uart[OPC_MSB:OPC_LSB];
                        cmd_addr <= io.data_from_uart[ADDR_MSB:ADDR_LSB];
                        busy_r   <= 1'b1;
                        state    <= DECODE;
                    end
                end

                DECODE: begin
                    case (cmd_op)
                        OP_WRITE: state <= GET_DATA;
                        OP_READ: begin
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= 1'b0;
                            bus_addr_r  <= cmd_addr[ADDR_W-1:0];
                            bus_wdata_r <= '0;
                            state       <= BUS;
                        end
                        OP_PING: begin
                            status <= ST_OK;
                            dout   <= hdr_word(ST_OK);
                            state  <= SEND_HDR;
                        end
                        default: begin
                            status <= ST_BAD_OP;
                            dout   <= hdr_word(ST_BAD_OP);
                            state  <= SEND_HDR;
                        end
                    endcase
                end

                GET_DATA: begin
                    if (!io.empty_in) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= 1'b1;
                        bus_addr_r  <= cmd_addr[ADDR_W-1:0];
                        bus_wdata_r <= io.data_from_uart;
                        state       <= BUS;
                    end
                end

                BUS: begin
                    // Ack is checked first so an ack in the expiry cycle wins.
                    if (io.bus_ack) begin
                        rdata     <= io.bus_rdata;
                        status    <= ST_OK;
                        dout      <= hdr_word(ST_OK);
                        bus_req_r <= 1'b0;
                        bus_we_r  <= 1'b0;
                        state     <= SEND_HDR;
                    end else if (tmr_expired) begin
                        rdata     <= '0;
                        status    <= ST_TIMEOUT;
                        dout      <= hdr_word(ST_TIMEOUT);
                        bus_req_r <= 1'b0;
                        bus_we_r  <= 1'b0;
                        state     <= SEND_HDR;
                    end
                end

                SEND_HDR: begin
                    if (!io.full_out) begin
                        if ((status != ST_OK) && !(&err_r)) begin
                            err_r <= err_r + ERR_W'(1);
                        end
                        if (cmd_op == OP_READ) begin
                            dout  <= rdata;
                            state <= SEND_DATA;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end

                SEND_DATA: begin
                    if (!io.full_out) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.bus_req          = bus_req_r;
    assign io.bus_we           = bus_we_r;
    assign io.bus_addr         = bus_addr_r;
    assign io.bus_wdata        = bus_wdata_r;
    assign io.data_from_system = dout;
    assign busy                = busy_r;
    assign err_count           = err_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Directed bench for uart_cmd_ctrl: models the UART input/output buffers and a
// register bus responder with programmable ack delay, then runs hand-computed
// command/response vectors.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.WORD_SIZE(32), .ADDR_W(16)) io ();

    uart_cmd_ctrl #(
        .WORD_SIZE   (32),
        .ADDR_W      (16),
        .BUS_TIMEOUT (255),
        .ERR_W       (8)
    ) dut (
        .clock     (clk),
        .reset     (rst_n),
        .io        (io),
        .busy      (busy),
        .err_count (err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Buffer / bus models
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    int          out_cyc_q[$];
    logic [31:0] mem [logic [15:0]];

    int          cyc            = 0;
    int          last_pop_cyc   = 0;
    int          ack_delay      = 1;   // ack in Nth bus_req cycle, 0 = never
    int          bus_cyc        = 0;
    int          bus_req_cycles = 0;
    logic        bus_unstable   = 1'b0;
    logic        ref_we         = 1'b0;
    logic [15:0] ref_addr       = '0;
    logic [31:0] ref_wdata      = '0;

    logic        s_pop  = 1'b0;
    logic        s_push = 1'b0;
    logic [31:0] s_dout = '0;

    // Handshakes sampled mid-low-phase; inputs do not move before the next edge.
    always begin
        @(negedge clk);
        #2;
        s_pop  = io.r_buff_in;
        s_push = io.w_buff_out;
        s_dout = io.data_from_system;
    end

    // Environment: applies the effects of each edge, then drives inputs.
    initial begin
        io.empty_in       = 1'b1;
        io.data_from_uart = '0;
        io.bus_ack        = 1'b0;
        io.bus_rdata      = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (s_pop && in_q.size() > 0) begin
                void'(in_q.pop_front());
                last_pop_cyc = cyc;
            end
            if (s_push) begin
                out_q.push_back(s_dout);
                out_cyc_q.push_back(cyc);
            end
            if (io.bus_req) begin
                bus_req_cycles++;
                bus_cyc++;
                if (bus_cyc == 1) begin
                    ref_we    = io.bus_we;
                    ref_addr  = io.bus_addr;
                    ref_wdata = io.bus_wdata;
                end else if (io.bus_we !== ref_we || io.bus_addr !== ref_addr ||
                             io.bus_wdata !== ref_wdata) begin
                    bus_unstable = 1'b1;
                end
                if (bus_cyc == ack_delay) begin
                    io.bus_ack = 1'b1;
                    if (io.bus_we) mem[io.bus_addr] = io.bus_wdata;
                    else io.bus_rdata = mem.exists(io.bus_addr) ? mem[io.bus_addr] : 32'h0;
                end else begin
                    io.bus_ack = 1'b0;
                end
            end else begin
                bus_cyc    = 0;
                io.bus_ack = 1'b0;
            end
            io.empty_in       = (in_q.size() == 0);
            io.data_from_uart = (in_q.size() == 0) ? 32'h0 : in_q[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_val("out_count", out_q.size(), n);
    endtask

    function automatic logic [31:0] out_at(input int i);
        return (out_q.size() > i) ? out_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int lat_at(input int i);
        return (out_cyc_q.size() > i) ? out_cyc_q[i] - last_pop_cyc : -1;
    endfunction

    task automatic clear_logs();
        out_q.delete();
        out_cyc_q.delete();
        bus_req_cycles = 0;
    endtask

    initial begin
        io.full_out = 1'b0;
        in_q.push_back(32'h0300_0012);
        #12;
        // Reset state: a queued command must not be popped while held
        check_val("rst_r_buff_in", io.r_buff_in, 0);
        check_val("rst_w_buff_out", io.w_buff_out, 0);
        check_val("rst_bus_req", io.bus_req, 0);
        check_val("rst_bus_we", io.bus_we, 0);
        check_val("rst_bus_addr", io.bus_addr, 0);
        check_val("rst_bus_wdata", io.bus_wdata, 0);
        check_val("rst_dout", io.data_from_system, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // PING
        wait_out(1, 20);
        check_val("ping_hdr", out_at(0), 32'h0300_0012);
        check_val("ping_latency", lat_at(0), 2);
        check_val("ping_no_bus", bus_req_cycles, 0);
        check_val("ping_err", err_count, 0);
        check_val("ping_busy", busy, 0);

        // WRITE, ack in 3rd bus cycle
        clear_logs();
        ack_delay = 3;
        in_q.push_back(32'h0100_0004);
        in_q.push_back(32'hDEAD_BEEF);
        wait_out(1, 40);
        check_val("wr_hdr", out_at(0), 32'h0100_0004);
        check_val("wr_we", ref_we, 1);
        check_val("wr_addr", ref_addr, 32'h0004);
        check_val("wr_wdata", ref_wdata, 32'hDEAD_BEEF);
        check_val("wr_req_cycles", bus_req_cycles, 3);

        // READ back, ack in 1st bus cycle
        clear_logs();
        ack_delay = 1;
        in_q.push_back(32'h0200_0004);
        wait_out(2, 40);
        check_val("rd_hdr", out_at(0), 32'h0200_0004);
        check_val("rd_data", out_at(1), 32'hDEAD_BEEF);
        check_val("rd_latency", lat_at(1), 4);
        check_val("rd_we", ref_we, 0);
        check_val("rd_busy", busy, 0);

        // READ timeout, no ack
        clear_logs();
        ack_delay = 0;
        in_q.push_back(32'h0200_0010);
        wait_out(2, 400);
        check_val("to_hdr", out_at(0), 32'h0202_0010);
        check_val("to_data", out_at(1), 32'h0000_0000);
        check_val("to_req_cycles", bus_req_cycles, 255);
        check_val("to_err", err_count, 1);

        // READ with ack exactly in the expiry cycle
        clear_logs();
        ack_delay = 255;
        mem[16'h0010] = 32'h1234_5678;
        in_q.push_back(32'h0200_0010);
        wait_out(2, 400);
        check_val("toack_hdr", out_at(0), 32'h0200_0010);
        check_val("toack_data", out_at(1), 32'h1234_5678);
        check_val("toack_req_cycles", bus_req_cycles, 255);
        check_val("toack_err", err_count, 1);

        // Bad opcode
        clear_logs();
        ack_delay = 1;
        in_q.push_back(32'h7F00_0001);
        wait_out(1, 20);
        check_val("bad_hdr", out_at(0), 32'h7F01_0001);
        check_val("bad_no_bus", bus_req_cycles, 0);
        check_val("bad_err", err_count, 2);

        // 300 bad opcodes: counter saturates
        clear_logs();
        for (int i = 0; i < 300; i++) in_q.push_back(32'h7F00_0000 | i);
        wait_out(300, 2000);
        check_val("sat_last_hdr", out_at(299), 32'h7F01_012B);
        check_val("sat_err", err_count, 32'hFF);
        check_val("sat_no_bus", bus_req_cycles, 0);

        // Backpressure on a READ response
        clear_logs();
        io.full_out = 1'b1;
        in_q.push_back(32'h0200_0004);
        tick(6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_w_buff_out", io.w_buff_out, 0);
            check_val("bp_dout_stable", io.data_from_system, 32'h0200_0004);
        end
        @(posedge clk);
        #3;
        check_val("bp_none_pushed", out_q.size(), 0);
        io.full_out = 1'b0;
        wait_out(2, 20);
        tick(5);
        check_val("bp_push_count", out_q.size(), 2);
        check_val("bp_hdr", out_at(0), 32'h0200_0004);
        check_val("bp_data", out_at(1), 32'hDEAD_BEEF);

        // Reset while waiting for WRITE data
        clear_logs();
        in_q.push_back(32'h0100_0020);
        tick(5);
        check_val("mid_busy_before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_err", err_count, 0);
        check_val("mid_rst_bus_req", io.bus_req, 0);
        check_val("mid_rst_w_buff_out", io.w_buff_out, 0);
        check_val("mid_rst_r_buff_in", io.r_buff_in, 0);
        check_val("mid_rst_dout", io.data_from_system, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_q.push_back(32'h0300_0055);
        wait_out(1, 20);
        check_val("mid_ping_hdr", out_at(0), 32'h0300_0055);
        check_val("mid_no_bus", bus_req_cycles, 0);
        check_val("mid_busy_after", busy, 0);

        check_val("bus_stable", bus_unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
